ifu_prefetch_queue: RTL and testbench



---
 rtl/riscv_pkg.sv | 10 +
 rtl/ifu_fifo.sv | 75 +++++++
 rtl/ifu_prefetch_queue.sv | 120 ++++++++++++
 tb/tb_ifu_prefetch_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: instruction/address widths and the canonical NOP.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  // addi x0, x0, 0
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifu_fifo.sv
// Circular buffer for the fetch queue: push/pop/flush, occupancy count and head read.
module ifu_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only visible through count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && (count_q == CW'(DEPTH))));
  assert property (@(posedge clk) disable iff (rst)
    !(pop_i && !flush_i && (count_q == '0)));

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch front end with prefetch queue, hold absorption and jump flush.
// Define IFU_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module ifu_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned   AW       = XLEN,
  parameter int unsigned   DW       = INST_W,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [DW-1:0] NOP      = DW'(INST_NOP)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          rom_req_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW-1:0] rom_data_i,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_flag_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          inst_valid_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    pend_addr_q, pend_addr_d;
  logic             rsp_pend_q, rsp_pend_d;

  logic [CW-1:0]    count;
  logic [CW:0]      occupancy;
  logic [AW+DW-1:0] head;
  logic             head_valid;
  logic             bypass;
  logic             pop;
  logic             fifo_push;
  logic             fifo_pop;
  logic [AW-1:0]    jump_target;
  logic             unused_jump_lsb;

  assign jump_target     = {jump_addr_i[AW-1:2], 2'b00};
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Entries held plus the one in flight; a same-cycle pop is deliberately not credited.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, rsp_pend_q};
  assign rom_req_o  = !rst && !jump_en_i && (occupancy < (CW+1)'(DEPTH));
  assign rom_addr_o = fetch_pc_q;

  assign head_valid = (count != '0);

`ifdef IFU_BYPASS_EN
  assign bypass = !head_valid && rsp_pend_q;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid_o = !jump_en_i && (head_valid || bypass);
  assign pop          = inst_valid_o && !hold_flag_i;
  assign fifo_pop     = pop && head_valid;
  // A bypassed response that is consumed immediately never needs a slot.
  assign fifo_push    = rsp_pend_q && !jump_en_i && !(bypass && pop);

  always_comb begin
    inst_o      = NOP;
    inst_addr_o = '0;
    if (inst_valid_o) begin
      if (bypass) begin
        inst_o      = rom_data_i;
        inst_addr_o = pend_addr_q;
      end else begin
        inst_o      = head[DW-1:0];
        inst_addr_o = head[AW+DW-1:DW];
      end
    end
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pend_addr_d = pend_addr_q;
    rsp_pend_d  = 1'b0;
    if (jump_en_i) begin
      fetch_pc_d = jump_target;
    end else if (rom_req_o) begin
      fetch_pc_d  = fetch_pc_q + AW'(4);
      pend_addr_d = fetch_pc_q;
      rsp_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= '0;
      rsp_pend_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      rsp_pend_q  <= rsp_pend_d;
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_en_i),
    .push_i  (fifo_push),
    .wdata_i ({pend_addr_q, rom_data_i}),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .count_o (count)
  );

  assert property (@(posedge clk) disable iff (rst)
    jump_en_i |-> (!rom_req_o && !inst_valid_o));

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed plus randomized bench for ifu_prefetch_queue against a queue-based reference model.
module tb_ifu_prefetch_queue;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_req_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic          jump_en_i;
  logic [AW-1:0] jump_addr_i;
  logic          hold_flag_i;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_addr_o;
  logic          inst_valid_o;

  ifu_prefetch_queue #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered addresses in order, plus the read in flight.
  logic [31:0] mq[$];
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_pc;
  logic [31:0] key;
  logic [31:0] rom_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit j, input logic [31:0] ja, input bit h);
    bit          e_req, e_valid, byp, pop;
    logic [31:0] head, e_iaddr, e_inst;
    @(negedge clk);
    rst         = r;
    jump_en_i   = j;
    jump_addr_i = ja;
    hold_flag_i = h;
    rom_data_i  = rom_next;
    if (r) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = RESET_PC;
    end
    #1;
    e_req   = !r && !j && ((mq.size() + int'(m_pend)) < DEPTH);
    byp     = BYP && (mq.size() == 0) && m_pend;
    e_valid = !r && !j && ((mq.size() != 0) || byp);
    head    = (mq.size() != 0) ? mq[0] : m_pend_addr;
    e_iaddr = e_valid ? head : 32'h0;
    e_inst  = e_valid ? (head ^ key) : NOP;
    chk("rom_req", {31'b0, rom_req_o}, {31'b0, e_req});
    chk("rom_addr", rom_addr_o, m_pc);
    chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, e_valid});
    chk("inst_addr", inst_addr_o, e_iaddr);
    chk("inst", inst_o, e_inst);
    // ROM answers the address actually requested; garbage otherwise.
    rom_next = rom_req_o ? (rom_addr_o ^ key) : $urandom;
    if (!r) begin
      if (j) begin
        mq.delete();
        m_pend = 1'b0;
        m_pc   = {ja[31:2], 2'b00};
      end else begin
        pop = e_valid && !h;
        if (m_pend) mq.push_back(m_pend_addr);
        if (pop) void'(mq.pop_front());
        if (e_req) begin
          m_pend      = 1'b1;
          m_pend_addr = m_pc;
          m_pc        = m_pc + 32'd4;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  endtask

  initial begin
    bit reached;
    rst         = 1'b1;
    jump_en_i   = 1'b0;
    jump_addr_i = '0;
    hold_flag_i = 1'b0;
    rom_data_i  = '0;
    key         = 32'hA5A5_0000 ^ ($urandom & 32'h0000_FFFF);
    rom_next    = '0;
    mq.delete();
    m_pend      = 1'b0;
    m_pend_addr = '0;
    m_pc        = RESET_PC;

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Three entries queued with a read in flight, then jump.
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (mq.size() == 3 && m_pend) reached = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("reach_q3_pend", {31'b0, reached}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Jump and hold together with a full queue.
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (mq.size() == DEPTH) reached = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("reach_full", {31'b0, reached}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 4));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset while a response is pending.
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (m_pend) reached = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("reach_pend", {31'b0, reached}, 32'd1);
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Fetch PC wraps past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF6, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
